// File: rtl/br_resolver_pkg.sv
// Shared definitions for the branch resolver: PC width, instruction length
// and the per-instruction prediction record captured at fetch.
package br_resolver_pkg;

   localparam int XLEN = 64;
   localparam logic [XLEN-1:0] INST_LEN = 64'd4;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic            pre_valid;
      logic [XLEN-1:0] pre_next_pc;
   } pred_entry_t;

endpackage

// File: rtl/br_resolver_if.sv
// Fetch / execute / update bundle between IFU, EXU, predictor and resolver.
//   master : IFU+EXU side, drives fetch and resolve requests
//   slave  : resolver side, drives ready, branch-update, redirect and status
interface br_resolver_if;
   import br_resolver_pkg::*;

   logic            io_fetch_valid;
   logic [XLEN-1:0] io_fetch_pc;
   logic            io_fetch_pre_valid;
   logic [XLEN-1:0] io_fetch_pre_next_pc;
   logic            io_fetch_ready;

   logic            io_ex_valid;
   logic [XLEN-1:0] io_ex_pc;
   logic            io_ex_is_br;
   logic            io_ex_taken;
   logic [XLEN-1:0] io_ex_target;

   logic            io_br_info_valid;
   logic            io_br_info_mispredict;
   logic [XLEN-1:0] io_br_info_br_pc;
   logic            io_br_info_taken;
   logic [XLEN-1:0] io_br_info_target_next_pc;

   logic            io_redirect_valid;
   logic [XLEN-1:0] io_redirect_pc;
   logic            io_err;
   logic [31:0]     io_mispredict_cnt;

   modport master (
      output io_fetch_valid, io_fetch_pc, io_fetch_pre_valid, io_fetch_pre_next_pc,
      output io_ex_valid, io_ex_pc, io_ex_is_br, io_ex_taken, io_ex_target,
      input  io_fetch_ready, io_br_info_valid, io_br_info_mispredict,
      input  io_br_info_br_pc, io_br_info_taken, io_br_info_target_next_pc,
      input  io_redirect_valid, io_redirect_pc, io_err, io_mispredict_cnt
   );

   modport slave (
      input  io_fetch_valid, io_fetch_pc, io_fetch_pre_valid, io_fetch_pre_next_pc,
      input  io_ex_valid, io_ex_pc, io_ex_is_br, io_ex_taken, io_ex_target,
      output io_fetch_ready, io_br_info_valid, io_br_info_mispredict,
      output io_br_info_br_pc, io_br_info_taken, io_br_info_target_next_pc,
      output io_redirect_valid, io_redirect_pc, io_err, io_mispredict_cnt
   );
endinterface

// File: rtl/br_pred_queue.sv
// In-order FIFO of fetch-time predictions.
//   clock/reset : clock, async active-low reset
//   flush       : synchronous clear (wins over push/pop)
//   push/push_data, pop : enqueue / dequeue head
//   head, full, empty   : oldest entry and occupancy flags
module br_pred_queue
   import br_resolver_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        flush,
   input  logic        push,
   input  pred_entry_t push_data,
   input  logic        pop,
   output pred_entry_t head,
   output logic        full,
   output logic        empty
);
   localparam int AW = $clog2(DEPTH);

   // Pointers carry one extra wrap bit to tell full from empty.
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   pred_entry_t mem_q [DEPTH];
   pred_entry_t mem_d [DEPTH];

   logic do_push;
   logic do_pop;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
   assign head    = mem_q[rd_ptr_q[AW-1:0]];
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         mem_q    <= mem_d;
      end
   end
endmodule

// File: rtl/br_resolver.sv
// Branch resolver: compares fetch-time predictions against execute results,
// emits a registered predictor-update record and the front-end redirect.
//   clock/reset : clock, async active-low reset
//   bus (slave) : fetch push, execute resolve, br_info update, redirect,
//                 sticky protocol error and mispredict counter
module br_resolver
   import br_resolver_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic         clock,
   input  logic         reset,
   br_resolver_if.slave bus
);
   pred_entry_t     head;
   pred_entry_t     push_data;
   logic            full, empty;
   logic            push, valid_res, mis, kill;
   logic [XLEN-1:0] seq_pc, actual_next, pred_next;

   logic            info_valid_q, info_valid_d;
   logic            info_mis_q, info_mis_d;
   logic [XLEN-1:0] info_br_pc_q, info_br_pc_d;
   logic            info_taken_q, info_taken_d;
   logic [XLEN-1:0] info_next_q, info_next_d;
   logic            redirect_q, redirect_d;
   logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
   logic            err_q, err_d;
   logic [31:0]     cnt_q, cnt_d;

   // The redirect cycle is wrong-path: resolves are ignored, pushes blocked.
   assign valid_res   = bus.io_ex_valid & ~empty & ~redirect_q;
   assign seq_pc      = bus.io_ex_pc + INST_LEN;
   assign actual_next = (bus.io_ex_is_br & bus.io_ex_taken) ? bus.io_ex_target : seq_pc;
   assign pred_next   = head.pre_valid ? head.pre_next_pc : seq_pc;
   assign mis         = (pred_next != actual_next);
   assign kill        = valid_res & mis;

   // Ready is held low while in reset so the port reads 0 until release.
   assign bus.io_fetch_ready = reset & ~full & ~kill & ~redirect_q;
   assign push               = bus.io_fetch_valid & bus.io_fetch_ready;
   assign push_data          = '{pc: bus.io_fetch_pc, pre_valid: bus.io_fetch_pre_valid,
                                 pre_next_pc: bus.io_fetch_pre_next_pc};

   br_pred_queue #(.DEPTH(DEPTH)) u_queue (
      .clock     (clock),
      .reset     (reset),
      .flush     (kill),
      .push      (push),
      .push_data (push_data),
      .pop       (valid_res),
      .head      (head),
      .full      (full),
      .empty     (empty)
   );

   always_comb begin
      info_valid_d  = 1'b0;
      info_mis_d    = 1'b0;
      info_br_pc_d  = '0;
      info_taken_d  = 1'b0;
      info_next_d   = '0;
      redirect_d    = kill;
      redirect_pc_d = '0;
      cnt_d         = cnt_q + {31'd0, kill};
      err_d         = err_q | (bus.io_ex_valid & empty & ~redirect_q)
                            | (valid_res & (bus.io_ex_pc != head.pc));
      if (valid_res) begin
         // Non-branches that hit in the BTB still update so the alias is cleared.
         info_valid_d = bus.io_ex_is_br | (head.pre_valid & mis);
         info_mis_d   = mis;
         info_br_pc_d = bus.io_ex_pc;
         info_taken_d = bus.io_ex_is_br & bus.io_ex_taken;
         info_next_d  = actual_next;
         if (kill) begin
            redirect_pc_d = actual_next;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         info_valid_q  <= 1'b0;
         info_mis_q    <= 1'b0;
         info_br_pc_q  <= '0;
         info_taken_q  <= 1'b0;
         info_next_q   <= '0;
         redirect_q    <= 1'b0;
         redirect_pc_q <= '0;
         err_q         <= 1'b0;
         cnt_q         <= '0;
      end else begin
         info_valid_q  <= info_valid_d;
         info_mis_q    <= info_mis_d;
         info_br_pc_q  <= info_br_pc_d;
         info_taken_q  <= info_taken_d;
         info_next_q   <= info_next_d;
         redirect_q    <= redirect_d;
         redirect_pc_q <= redirect_pc_d;
         err_q         <= err_d;
         cnt_q         <= cnt_d;
      end
   end

   assign bus.io_br_info_valid          = info_valid_q;
   assign bus.io_br_info_mispredict     = info_mis_q;
   assign bus.io_br_info_br_pc          = info_br_pc_q;
   assign bus.io_br_info_taken          = info_taken_q;
   assign bus.io_br_info_target_next_pc = info_next_q;
   assign bus.io_redirect_valid         = redirect_q;
   assign bus.io_redirect_pc            = redirect_pc_q;
   assign bus.io_err                    = err_q;
   assign bus.io_mispredict_cnt         = cnt_q;
endmodule

// File: tb/tb_br_resolver.sv
// Directed bench for br_resolver with hand-computed expected values.
module tb_br_resolver;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   br_resolver_if bus ();

   br_resolver #(.DEPTH(4)) dut (
      .clock (clk),
      .reset (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [63:0] pc, input logic pv, input logic [63:0] pn);
      bus.io_fetch_valid       = 1'b1;
      bus.io_fetch_pc          = pc;
      bus.io_fetch_pre_valid   = pv;
      bus.io_fetch_pre_next_pc = pn;
      step();
      bus.io_fetch_valid = 1'b0;
   endtask

   task automatic set_ex(input logic [63:0] pc, input logic br, input logic tk, input logic [63:0] tgt);
      bus.io_ex_valid  = 1'b1;
      bus.io_ex_pc     = pc;
      bus.io_ex_is_br  = br;
      bus.io_ex_taken  = tk;
      bus.io_ex_target = tgt;
   endtask

   task automatic resolve(input logic [63:0] pc, input logic br, input logic tk, input logic [63:0] tgt);
      set_ex(pc, br, tk, tgt);
      step();
      bus.io_ex_valid = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      bus.io_fetch_valid = 1'b0;
      bus.io_fetch_pc = '0;
      bus.io_fetch_pre_valid = 1'b0;
      bus.io_fetch_pre_next_pc = '0;
      bus.io_ex_valid = 1'b0;
      bus.io_ex_pc = '0;
      bus.io_ex_is_br = 1'b0;
      bus.io_ex_taken = 1'b0;
      bus.io_ex_target = '0;

      // Reset state
      #2;
      chk("rst_ready", bus.io_fetch_ready, 0);
      chk("rst_info_valid", bus.io_br_info_valid, 0);
      chk("rst_redirect", bus.io_redirect_valid, 0);
      chk("rst_err", bus.io_err, 0);
      chk("rst_cnt", bus.io_mispredict_cnt, 0);
      step();
      rst_n = 1'b1;
      #1;
      chk("rel_ready", bus.io_fetch_ready, 1);

      // Non-branch, no prediction: no update, no redirect
      push(64'h8000_0000, 1'b0, 64'h0);
      resolve(64'h8000_0000, 1'b0, 1'b0, 64'h0);
      chk("nb_info_valid", bus.io_br_info_valid, 0);
      chk("nb_redirect", bus.io_redirect_valid, 0);
      chk("nb_err", bus.io_err, 0);

      // Correctly predicted taken branch
      push(64'h8000_0010, 1'b1, 64'h8000_0040);
      resolve(64'h8000_0010, 1'b1, 1'b1, 64'h8000_0040);
      chk("hit_info_valid", bus.io_br_info_valid, 1);
      chk("hit_mis", bus.io_br_info_mispredict, 0);
      chk("hit_taken", bus.io_br_info_taken, 1);
      chk("hit_br_pc", bus.io_br_info_br_pc, 64'h8000_0010);
      chk("hit_next", bus.io_br_info_target_next_pc, 64'h8000_0040);
      chk("hit_redirect", bus.io_redirect_valid, 0);
      chk("hit_cnt", bus.io_mispredict_cnt, 0);

      // Mispredicted taken branch with two younger entries
      push(64'h8000_0020, 1'b0, 64'h0);
      push(64'h8000_0024, 1'b0, 64'h0);
      push(64'h8000_0028, 1'b0, 64'h0);
      set_ex(64'h8000_0020, 1'b1, 1'b1, 64'h8000_0100);
      bus.io_fetch_valid = 1'b1;
      bus.io_fetch_pc = 64'h8000_0999;
      bus.io_fetch_pre_valid = 1'b0;
      #1;
      chk("kill_ready", bus.io_fetch_ready, 0);
      step();
      chk("mp_redirect", bus.io_redirect_valid, 1);
      chk("mp_redirect_pc", bus.io_redirect_pc, 64'h8000_0100);
      chk("mp_info_valid", bus.io_br_info_valid, 1);
      chk("mp_mis", bus.io_br_info_mispredict, 1);
      chk("mp_cnt", bus.io_mispredict_cnt, 1);
      chk("redir_ready", bus.io_fetch_ready, 0);
      // Wrong-path activity during the redirect cycle
      bus.io_fetch_pc = 64'h9000_0000;
      set_ex(64'h8000_0024, 1'b0, 1'b0, 64'h0);
      step();
      bus.io_fetch_valid = 1'b0;
      bus.io_ex_valid = 1'b0;
      chk("post_redirect", bus.io_redirect_valid, 0);
      chk("post_info_valid", bus.io_br_info_valid, 0);
      chk("post_err", bus.io_err, 0);
      chk("post_cnt", bus.io_mispredict_cnt, 1);
      // Queue must be empty: the next pushed entry is the head
      push(64'h8000_0100, 1'b0, 64'h0);
      resolve(64'h8000_0100, 1'b0, 1'b0, 64'h0);
      chk("flush_head_err", bus.io_err, 0);
      chk("flush_head_redirect", bus.io_redirect_valid, 0);

      // Non-branch aliasing in the BTB
      push(64'h8000_0200, 1'b1, 64'h8000_0300);
      resolve(64'h8000_0200, 1'b0, 1'b0, 64'h0);
      chk("alias_info_valid", bus.io_br_info_valid, 1);
      chk("alias_mis", bus.io_br_info_mispredict, 1);
      chk("alias_taken", bus.io_br_info_taken, 0);
      chk("alias_next", bus.io_br_info_target_next_pc, 64'h8000_0204);
      chk("alias_redirect_pc", bus.io_redirect_pc, 64'h8000_0204);
      chk("alias_cnt", bus.io_mispredict_cnt, 2);
      step();

      // Fill, blocked push, simultaneous push/pop, wrap order
      for (int i = 0; i < 4; i++) push(64'h1000 + 64'(4 * i), 1'b0, 64'h0);
      chk("full_ready", bus.io_fetch_ready, 0);
      push(64'h2000, 1'b0, 64'h0);
      resolve(64'h1000, 1'b0, 1'b0, 64'h0);
      chk("pop0_err", bus.io_err, 0);
      bus.io_fetch_valid = 1'b1;
      bus.io_fetch_pc = 64'h1010;
      bus.io_fetch_pre_valid = 1'b0;
      resolve(64'h1004, 1'b0, 1'b0, 64'h0);
      bus.io_fetch_valid = 1'b0;
      chk("pushpop_ready", bus.io_fetch_ready, 1);
      push(64'h1014, 1'b0, 64'h0);
      chk("refill_ready", bus.io_fetch_ready, 0);
      for (int i = 0; i < 4; i++) begin
         resolve(64'h1008 + 64'(4 * i), 1'b0, 1'b0, 64'h0);
         chk("order_err", bus.io_err, 0);
      end
      chk("drain_ready", bus.io_fetch_ready, 1);

      // Resolve on empty queue sets a sticky error
      resolve(64'h5000, 1'b0, 1'b0, 64'h0);
      chk("empty_err", bus.io_err, 1);
      chk("empty_info_valid", bus.io_br_info_valid, 0);
      step(); step(); step();
      chk("sticky_err", bus.io_err, 1);

      // Reset mid-stream with three entries
      push(64'h6000, 1'b0, 64'h0);
      push(64'h6004, 1'b0, 64'h0);
      push(64'h6008, 1'b0, 64'h0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_err", bus.io_err, 0);
      chk("mid_rst_cnt", bus.io_mispredict_cnt, 0);
      chk("mid_rst_ready", bus.io_fetch_ready, 0);
      chk("mid_rst_redirect_pc", bus.io_redirect_pc, 0);
      step();
      rst_n = 1'b1;
      #1;
      chk("rel2_ready", bus.io_fetch_ready, 1);
      chk("rel2_cnt", bus.io_mispredict_cnt, 0);
      chk("rel2_err", bus.io_err, 0);
      resolve(64'h6000, 1'b0, 1'b0, 64'h0);
      chk("rel2_empty_err", bus.io_err, 1);

      // Head PC mismatch
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      #1;
      push(64'h8000_0000, 1'b0, 64'h0);
      resolve(64'h8000_0004, 1'b0, 1'b0, 64'h0);
      chk("pc_mismatch_err", bus.io_err, 1);
      chk("pc_mismatch_redirect", bus.io_redirect_valid, 0);
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
